ex_mem_pipe: RTL

- Parametrised successor to the fixed EX/MEM latch: an elastic pipeline of DEPTH register stages carrying a control field and a data field between EX and MEM.
- Per-stage valid bits, valid/ready backpressure, bubble collapsing, and a pipeline flush for branch/jump redirect.
- Invalid stages present all-zero control, so downstream regwrite/memwrite/memread bits can never fire from a bubble.

---
 rtl/ex_mem_pipe_if.sv | 25 ++
 rtl/ex_mem_pipe.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if: EX->MEM handshake bundle. The master side is EX plus MEM.
// The slave side is the pipeline itself.
interface ex_mem_pipe_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: elastic DEPTH-stage EX->MEM pipeline with bubble collapsing and redirect flush.
// Defining EX_MEM_PIPE_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module ex_mem_pipe #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  ex_mem_pipe_if.slave     bus,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy
`ifdef EX_MEM_PIPE_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  v_nxt;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  up_v;
  logic [CTRL_W-1:0] c    [DEPTH];
  logic [DATA_W-1:0] d    [DEPTH];
  logic [CTRL_W-1:0] up_c [DEPTH];
  logic [DATA_W-1:0] up_d [DEPTH];
  logic              in_ready;
  logic              accept;
  logic [CNT_W-1:0]  occ_nxt;

  // A stage may advance when any stage between it and MEM is empty, or MEM drains.
  always_comb begin : adv_chain
    logic hole;
    hole = bus.out_ready;
    adv  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hole   = hole | ~v[i];
      adv[i] = hole;
    end
  end

  assign in_ready = adv[0] & ~flush & ~rst;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    up_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      up_c[i] = '0;
      up_d[i] = '0;
    end
    up_v[0] = accept;
    up_c[0] = bus.in_ctrl;
    up_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_c[i] = c[i-1];
      up_d[i] = d[i-1];
    end
  end

  // Occupancy is registered from the next-state valid vector, so it always matches popcount(v).
  always_comb begin
    v_nxt = v;
    if (flush) begin
      v_nxt = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_nxt[i] = up_v[i];
        end
      end
    end
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + CNT_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c[i] <= '0;
        d[i] <= '0;
      end
    end else begin
      v         <= v_nxt;
      occupancy <= occ_nxt;
      // Flush kills control only; the data payload is left in place.
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          c[i] <= '0;
        end else if (adv[i]) begin
          c[i] <= up_v[i] ? up_c[i] : '0;
          d[i] <= up_d[i];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_ctrl  = c[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

`ifdef EX_MEM_PIPE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (v[DEPTH-1] && !bus.out_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && occupancy != '0 && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
